// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared constants and types for the SCC register file
package scc_pkg;

  // Hardwired zero register index
  localparam int REG_ZERO = 7;

  // Bit positions of the condition flags inside the 4-bit NZCV field
  localparam int CPSR_N = 3;
  localparam int CPSR_Z = 2;
  localparam int CPSR_C = 1;
  localparam int CPSR_V = 0;

  // Default PC increment per sequential step
  localparam int PC_STEP_DEF = 4;

  // {N,Z,C,V}
  typedef logic [3:0] flags_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write bits with busy lookup for three read ports
module reg_scoreboard
  import scc_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = REG_ZERO,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  output logic              busy1,
  output logic              busy2,
  output logic              busy3
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] pending;
  logic                wr_fwd;

  // Clear on writeback, then set on issue so a same-edge new producer wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (write_enable) begin
        pending[write_addr] <= 1'b0;
      end
      if (issue_valid && (issue_addr != ADDR_W'(ZERO_REG))) begin
        pending[issue_addr] <= 1'b1;
      end
    end
  end

  // A writeback landing this cycle already satisfies the consumer when forwarded
  assign wr_fwd = write_enable & (BYPASS != 0);

  assign busy1 = pending[addr1] & ~(wr_fwd & (write_addr == addr1));
  assign busy2 = pending[addr2] & ~(wr_fwd & (write_addr == addr2));
  assign busy3 = pending[addr3] & ~(wr_fwd & (write_addr == addr3));

endmodule

// File: rtl/reg_file_sys.sv
// rtl/reg_file_sys.sv - user register file with bypass, scoreboard, PC and CPSR
module reg_file_sys
  import scc_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 3,
  parameter int                 ZERO_REG = REG_ZERO,
  parameter logic [DATA_W-1:0]  PC_RESET = '0,
  parameter int                 PC_STEP  = PC_STEP_DEF,
  parameter int                 BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [DATA_W-1:0] value1,
  output logic [DATA_W-1:0] value2,
  output logic [DATA_W-1:0] br_value,
  output logic              busy1,
  output logic              busy2,
  output logic              br_busy,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_value,
  input  logic              write_enable,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] pc_load_value,
  output logic [DATA_W-1:0] pc,
  input  logic              flags_we,
  input  logic [3:0]        flags_in,
  output logic [DATA_W-1:0] cpsr
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] pc_q;
  flags_t            flags_q;

  // Zero register reads 0; a matching writeback is forwarded when bypass is built in
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] stored);
    if (a == ADDR_W'(ZERO_REG)) begin
      return '0;
    end else if ((BYPASS != 0) && write_enable && (write_addr == a)) begin
      return write_value;
    end else begin
      return stored;
    end
  endfunction

  assign value1   = read_port(read_addr1, regs[read_addr1]);
  assign value2   = read_port(read_addr2, regs[read_addr2]);
  assign br_value = read_port(br_addr,    regs[br_addr]);

  // User register storage; writes aimed at the zero register are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable && (write_addr != ADDR_W'(ZERO_REG))) begin
      regs[write_addr] <= write_value;
    end
  end

  // Branch target load takes priority over sequential increment; add wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
    end else if (pc_load) begin
      pc_q <= pc_load_value;
    end else if (pc_inc) begin
      pc_q <= pc_q + DATA_W'(PC_STEP);
    end
  end

  // Condition flags latch only on an explicit update strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (flags_we) begin
      flags_q <= flags_in;
    end
  end

  assign pc   = pc_q;
  assign cpsr = {flags_q[CPSR_N], flags_q[CPSR_Z], flags_q[CPSR_C], flags_q[CPSR_V],
                 {(DATA_W-4){1'b0}}};

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .addr1        (read_addr1),
    .addr2        (read_addr2),
    .addr3        (br_addr),
    .busy1        (busy1),
    .busy2        (busy2),
    .busy3        (br_busy)
  );

endmodule

// File: tb/tb_reg_file_sys.sv
// tb/tb_reg_file_sys.sv - directed table-driven bench for reg_file_sys
module tb_reg_file_sys;

  logic        clk;
  logic        rst_n;
  logic [2:0]  read_addr1, read_addr2, br_addr;
  logic [2:0]  write_addr, issue_addr;
  logic [31:0] write_value, pc_load_value;
  logic        write_enable, issue_valid, pc_inc, pc_load, flags_we;
  logic [3:0]  flags_in;

  logic [31:0] value1, value2, br_value, pc, cpsr;
  logic        busy1, busy2, br_busy;
  logic [31:0] nb_value1, nb_value2, nb_br_value, nb_pc, nb_cpsr;
  logic        nb_busy1, nb_busy2, nb_br_busy;

  int checks = 0;
  int errors = 0;

  reg_file_sys u_dut (
    .clk(clk), .rst_n(rst_n),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .br_addr(br_addr),
    .value1(value1), .value2(value2), .br_value(br_value),
    .busy1(busy1), .busy2(busy2), .br_busy(br_busy),
    .write_addr(write_addr), .write_value(write_value), .write_enable(write_enable),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_value(pc_load_value), .pc(pc),
    .flags_we(flags_we), .flags_in(flags_in), .cpsr(cpsr)
  );

  reg_file_sys #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .br_addr(br_addr),
    .value1(nb_value1), .value2(nb_value2), .br_value(nb_br_value),
    .busy1(nb_busy1), .busy2(nb_busy2), .br_busy(nb_br_busy),
    .write_addr(write_addr), .write_value(write_value), .write_enable(write_enable),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_value(pc_load_value), .pc(nb_pc),
    .flags_we(flags_we), .flags_in(flags_in), .cpsr(nb_cpsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wv;
    logic        iv;
    logic [2:0]  ia;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [2:0]  ba;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] eb;
    logic        b1;
    logic        b2;
    logic        bb;
    logic [31:0] nb1;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b1, 3'd3, 32'h1234_5678, 1'b0, 3'd0, 3'd3, 3'd2, 3'd3,
                 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd3, 3'd7, 3'd0,
                 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1234_5678};
    vecs[2]  = '{1'b1, 3'd7, 32'hFFFF_FFFF, 1'b1, 3'd7, 3'd7, 3'd3, 3'd7,
                 32'h0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd7, 3'd3, 3'd7,
                 32'h0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 3'd0, 32'h0, 1'b1, 3'd1, 3'd1, 3'd1, 3'd1,
                 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd1, 3'd1, 3'd1,
                 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 3'd1, 32'hAAAA_5555, 1'b0, 3'd0, 3'd1, 3'd1, 3'd1,
                 32'hAAAA_5555, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd1, 3'd1, 3'd1,
                 32'hAAAA_5555, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, 32'hAAAA_5555};
    vecs[8]  = '{1'b1, 3'd1, 32'h1111_2222, 1'b1, 3'd1, 3'd1, 3'd1, 3'd1,
                 32'h1111_2222, 32'h1111_2222, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 32'hAAAA_5555};
    vecs[9]  = '{1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd1, 3'd1, 3'd1,
                 32'h1111_2222, 32'h1111_2222, 32'h1111_2222, 1'b1, 1'b1, 1'b1, 32'h1111_2222};
    vecs[10] = '{1'b0, 3'd0, 32'h0, 1'b1, 3'd1, 3'd1, 3'd1, 3'd1,
                 32'h1111_2222, 32'h1111_2222, 32'h1111_2222, 1'b1, 1'b1, 1'b1, 32'h1111_2222};
    vecs[11] = '{1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd1, 3'd1, 3'd1,
                 32'h1111_2222, 32'h1111_2222, 32'h1111_2222, 1'b1, 1'b1, 1'b1, 32'h1111_2222};
    vecs[12] = '{1'b1, 3'd1, 32'h0BAD_F00D, 1'b0, 3'd0, 3'd1, 3'd1, 3'd1,
                 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 32'h1111_2222};
    vecs[13] = '{1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd1, 3'd3, 3'd2,
                 32'h0BAD_F00D, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0BAD_F00D};

    rst_n = 1'b0;
    read_addr1 = '0; read_addr2 = '0; br_addr = '0;
    write_addr = '0; write_value = '0; write_enable = 1'b0;
    issue_valid = 1'b0; issue_addr = '0;
    pc_inc = 1'b0; pc_load = 1'b0; pc_load_value = '0;
    flags_we = 1'b0; flags_in = '0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      read_addr1 = 3'(i); read_addr2 = 3'(i); br_addr = 3'(i);
      #1;
      chk($sformatf("rst_value1_r%0d", i), value1, 32'h0);
      chk($sformatf("rst_value2_r%0d", i), value2, 32'h0);
      chk($sformatf("rst_br_value_r%0d", i), br_value, 32'h0);
      chk($sformatf("rst_busy_r%0d", i), {29'h0, busy1, busy2, br_busy}, 32'h0);
    end
    chk("rst_pc", pc, 32'h0);
    chk("rst_cpsr", cpsr, 32'h0);

    // Reset asserted while a write and an issue are in flight
    @(negedge clk);
    write_enable = 1'b1; write_addr = 3'd2; write_value = 32'hDEAD_BEEF;
    issue_valid = 1'b1; issue_addr = 3'd4;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0; issue_valid = 1'b0;
    rst_n = 1'b1;
    read_addr1 = 3'd2; read_addr2 = 3'd4;
    #1;
    chk("rst_mid_write_r2", value1, 32'h0);
    chk("rst_mid_issue_busy_r4", {31'h0, busy2}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      write_enable = vecs[i].we; write_addr = vecs[i].wa; write_value = vecs[i].wv;
      issue_valid = vecs[i].iv; issue_addr = vecs[i].ia;
      read_addr1 = vecs[i].ra1; read_addr2 = vecs[i].ra2; br_addr = vecs[i].ba;
      #2;
      chk($sformatf("v%0d_value1", i), value1, vecs[i].e1);
      chk($sformatf("v%0d_value2", i), value2, vecs[i].e2);
      chk($sformatf("v%0d_br_value", i), br_value, vecs[i].eb);
      chk($sformatf("v%0d_busy1", i), {31'h0, busy1}, {31'h0, vecs[i].b1});
      chk($sformatf("v%0d_busy2", i), {31'h0, busy2}, {31'h0, vecs[i].b2});
      chk($sformatf("v%0d_br_busy", i), {31'h0, br_busy}, {31'h0, vecs[i].bb});
      chk($sformatf("v%0d_nobypass_value1", i), nb_value1, vecs[i].nb1);
    end

    @(negedge clk);
    write_enable = 1'b0; issue_valid = 1'b0;
    #1;
    chk("nb_value2", nb_value2, 32'h1234_5678);
    chk("nb_br_value", nb_br_value, 32'h0);
    chk("nb_busy", {29'h0, nb_busy1, nb_busy2, nb_br_busy}, 32'h0);

    // Without bypass a pending register stays busy during its own writeback cycle
    issue_valid = 1'b1; issue_addr = 3'd5; read_addr1 = 3'd5;
    @(negedge clk);
    issue_valid = 1'b0;
    write_enable = 1'b1; write_addr = 3'd5; write_value = 32'h5555_0005;
    #1;
    chk("nb_busy1_during_wb", {31'h0, nb_busy1}, 32'h1);
    chk("bp_busy1_during_wb", {31'h0, busy1}, 32'h0);
    @(negedge clk);
    write_enable = 1'b0;
    #1;
    chk("nb_value1_after_wb", nb_value1, 32'h5555_0005);

    // PC load, wrap, hold, load-over-inc priority
    pc_load = 1'b1; pc_load_value = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_load = 1'b0;
    chk("pc_load", pc, 32'hFFFF_FFFC);
    pc_inc = 1'b1;
    @(negedge clk);
    pc_inc = 1'b0;
    chk("pc_wrap", pc, 32'h0);
    @(negedge clk);
    chk("pc_hold", pc, 32'h0);
    pc_load = 1'b1; pc_inc = 1'b1; pc_load_value = 32'h100;
    @(negedge clk);
    pc_load = 1'b0;
    chk("pc_load_prio", pc, 32'h100);
    @(negedge clk);
    pc_inc = 1'b0;
    chk("pc_inc", pc, 32'h104);
    chk("nb_pc", nb_pc, 32'h104);

    // CPSR latch and hold
    flags_we = 1'b1; flags_in = 4'b1010;
    @(negedge clk);
    flags_we = 1'b0; flags_in = 4'b0101;
    chk("cpsr_write", cpsr, 32'hA000_0000);
    repeat (2) @(negedge clk);
    chk("cpsr_hold", cpsr, 32'hA000_0000);
    chk("nb_cpsr", nb_cpsr, 32'hA000_0000);

    // Asynchronous reset takes effect without a clock edge
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_cpsr", cpsr, 32'h0);
    read_addr1 = 3'd3;
    #1;
    chk("async_rst_r3", value1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sys.md
Name: reg_file_sys

Overview:
Parametrised successor to the user register file for the SCC-Unix core. It keeps the three combinational read ports (two operands plus branch target) and adds:
- a hardwired zero register
- write-to-read bypass
- a pending-write scoreboard for pipeline hazard detection
- the reserved, non-user-accessible system state: PC and CPSR (NZCV)

It sits between ID (reads, issue) and WB (writeback).

Parameters:
DATA_W, 32, register and PC width
ADDR_W, 3, user register address width; NUM_REGS = 2**ADDR_W
ZERO_REG, 7, index of the hardwired zero register
PC_RESET, 0, PC value after reset
PC_STEP, 4, PC increment per pc_inc
BYPASS, 1, 1 = same-cycle writeback forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
read_addr1  in  ADDR_W  operand port 1 address
read_addr2  in  ADDR_W  operand port 2 address
br_addr  in  ADDR_W  branch-register port address
value1  out  DATA_W  data at read_addr1
value2  out  DATA_W  data at read_addr2
br_value  out  DATA_W  data at br_addr
busy1  out  1  read_addr1 has an outstanding write
busy2  out  1  read_addr2 has an outstanding write
br_busy  out  1  br_addr has an outstanding write
write_addr  in  ADDR_W  writeback address
write_value  in  DATA_W  writeback data
write_enable  in  1  writeback strobe
issue_valid  in  1  instruction with destination issued this cycle
issue_addr  in  ADDR_W  destination of issued instruction
pc_inc  in  1  PC <= PC + PC_STEP
pc_load  in  1  PC <= pc_load_value
pc_load_value  in  DATA_W  branch target
pc  out  DATA_W  current PC
flags_we  in  1  update CPSR flags
flags_in  in  4  {N,Z,C,V}
cpsr  out  DATA_W  {N,Z,C,V} in [DATA_W-1:DATA_W-4], other bits 0

Behaviour:
- Reset (rst_n low, async, takes effect immediately, any cycle):
  - all user registers 0
  - pc = PC_RESET
  - cpsr = 0
  - all pending bits 0, hence busy1, busy2, br_busy = 0
  - a reset mid-operation drops any in-flight write or issue.
- Reads are combinational, 0-cycle latency. Address ZERO_REG always reads 0 and is never busy.
- Write: on a rising edge with write_enable=1 and write_addr != ZERO_REG, registers[write_addr] <= write_value. Writes to ZERO_REG are discarded.
- Bypass (BYPASS=1): if write_enable=1, write_addr == a port address, and that address != ZERO_REG, the port returns write_value in the same cycle.
  - Applies independently to all three ports.
  - With BYPASS=0 the port returns the old value until the next cycle.
- Scoreboard: one pending bit per register.
  - Rising edge, issue_valid=1 and issue_addr != ZERO_REG: set pending[issue_addr].
  - Rising edge, write_enable=1: clear pending[write_addr].
  - Same edge, same address, both events: set wins (new producer outstanding).
  - Issue to an already-pending register leaves it pending; no counting, single outstanding producer per register assumed by the pipeline.
- Busy outputs: busyX = pending[addr] & ~(write_enable & write_addr == addr) when BYPASS=1; busyX = pending[addr] when BYPASS=0.
- PC: pc_load has priority over pc_inc. Neither asserted: hold. Addition wraps modulo 2**DATA_W (e.g. 0xFFFF_FFFC + 4 = 0).
- CPSR: flags_we=1 latches flags_in into the top 4 bits on the edge. Low bits are reserved, read 0, never written.
- PC and CPSR are not addressable through the user read/write ports.

Decomposition:
- Shared package scc_pkg:
  - REG_ZERO = 7
  - CPSR bit positions CPSR_N/Z/C/V
  - PC_STEP default
  - a flags typedef (4-bit NZCV)
- One sub-module: reg_scoreboard (pending-bit vector with set/clear and busy lookup for three addresses).
- Storage, bypass and PC/CPSR logic stay in reg_file_sys.

Test Plan:
1. Reset, then read all 8 addresses -> all values 0, busy all 0, pc=PC_RESET, cpsr=0. Assert rst_n low mid-write of 0xDEAD_BEEF to r2 -> r2 reads 0 after release.
2. Write r3=0x1234_5678 with read_addr1=3 in the same cycle -> value1=0x1234_5678 that cycle (BYPASS=1); BYPASS=0 build -> old value 0, new value next cycle.
3. Write r7=0xFFFF_FFFF, issue r7 -> value1 (addr 7) stays 0, busy1 stays 0.
4. Issue r1; next cycle busy1=1 with read_addr1=1. Writeback r1 that cycle -> busy1=0 combinationally. Same-edge issue+writeback of r1 -> busy1=1 next cycle.
5. Set pc=0xFFFF_FFFC by load, then pc_inc -> pc=0. pc_load=1 and pc_inc=1 with pc_load_value=0x100 -> pc=0x100.
6. flags_we with flags_in=4'b1010 -> cpsr=0xA000_0000. flags_we=0 on later cycles -> cpsr holds.
